mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage pipeline, between the EX/MEM pipeline register and the write stage. ALU-only instructions pass through with one cycle of latency. Loads and stores are issued to the data memory over a req/ack handshake, and the upstream pipeline is stalled until the memory acknowledges. The stage registers everything the write stage needs: PC, ALU result, load data, destination register, write enable and mem-read select. It also keeps a saturating stall-cycle counter.

## Interface
- PC_W, 13, PC width
- DATA_W, 32, data and ALU result width
- REG_W, 3, register index width (8 registers)
- DADDR_W, 13, data-memory word-address width; taken from ALU result [DADDR_W-1:0]
- clk  in  1  clock. One clock; all state updates on the rising edge.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- ex_valid  in  1  EX/MEM register holds a live instruction
- ex_pc  in  PC_W  instruction PC
- ex_alu_res  in  DATA_W  ALU result; also the memory address
- ex_store_data  in  DATA_W  store data
- ex_write_reg  in  REG_W  destination register
- ex_write_en  in  1  register write enable
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- mem_stall  out  1  hold EX/MEM and all earlier stages (combinational)
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  store when 1
- dmem_addr  out  DADDR_W  word address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  access complete; dmem_rdata is valid in the same cycle
- dmem_rdata  in  DATA_W  load data
- wb_valid, wb_pc, wb_alu_res, wb_mem_data, wb_write_reg, wb_write_en, wb_mem_read  out  1/PC_W/DATA_W/DATA_W/REG_W/1/1  registered outputs to the write stage
- stall_count  out  16  cycles with mem_stall=1, saturating

## Operation
- The FSM has two states: IDLE and ACCESS.
- memop = ex_valid & (ex_mem_read | ex_mem_write).
- mem_stall = (IDLE & memop) | (ACCESS & ~dmem_ack).

IDLE behaviour:
- ex_valid & ~memop: the WB registers load the ex fields at the edge.
  - wb_valid=1, wb_mem_data=0.
- memop: the block latches the operation at the edge and moves to ACCESS.
  - Latched values: dmem_addr=ex_alu_res[12:0], dmem_wdata=ex_store_data, dmem_we=ex_mem_write, plus the ex fields.
  - dmem_req becomes 1 at that edge.
  - wb_valid becomes 0 (bubble).
- ~ex_valid: wb_valid=0 and wb_write_en=0. The other WB registers hold their values.

ACCESS behaviour:
- dmem_req, dmem_we, dmem_addr and dmem_wdata stay stable until ack.
- Edge with dmem_ack=1:
  - WB registers load the latched fields, with wb_valid=1.
  - wb_mem_data = dmem_rdata if the latched mem_read is 1, else 0.
  - dmem_req goes to 0 and the FSM returns to IDLE.
- mem_stall drops in the ack cycle, so upstream advances on the same edge. The next instruction is evaluated in IDLE on the following cycle.

Other rules:
- dmem_ack is ignored in IDLE.
- mem_read and mem_write both set: a single access is issued with dmem_we=1. wb_mem_data captures dmem_rdata.
- wb_write_en is always 0 when wb_valid is 0.
- stall_count increments on every edge where mem_stall=1. It holds at 0xFFFF and clears only on reset.
- Reset (including mid-ACCESS):
  - FSM goes to IDLE and dmem_req=0.
  - All registered outputs and stall_count go to 0.
  - The pending access is abandoned; a late ack is ignored.

## Timing
- Non-memory instruction: 1 cycle from ex_* to wb_*. No stall.
- Memory instruction accepted at edge T:
  - dmem_req is high from T.
  - The earliest ack is in the cycle after T, so WB is valid at T+1 at the earliest. That is 2 edges of latency with one bubble.
  - Each extra ack wait cycle adds one cycle to the latency.
- Stall cycles per memory op = 1 + number of ack wait cycles after dmem_req rises. Minimum is 1.
- Back-to-back memory ops: the second is accepted on the edge after the first's ack edge. dmem_req goes low for exactly one cycle between them.
- mem_stall is combinational from ex_valid, ex_mem_read, ex_mem_write, state and dmem_ack. It has no path from dmem_rdata.

## Test plan
- Reset:
  - Stimulus: rst_n=0 with random inputs, then release.
  - Required: all outputs 0, dmem_req=0, stall_count=0.
- ALU passthrough:
  - Stimulus: ex_pc=0x0010, alu=0x12345678, reg=5, we=1.
  - Required: the next edge gives wb_valid=1 with the same fields, wb_mem_data=0, mem_stall=0 throughout.
- Load with 2-cycle ack wait:
  - Stimulus: alu=0x00001ABC, mem_read=1, ack asserted 3 cycles after the request with rdata=0xDEADBEEF.
  - Required: dmem_addr=0x1ABC; wb_mem_data=0xDEADBEEF and wb_mem_read=1 on the ack edge; stall_count=3.
- Store then immediate load:
  - Stimulus: store (wdata 0xCAFEF00D, ack on the first request cycle) followed directly by a load.
  - Required: dmem_we=1 then 0; dmem_req low for exactly one cycle between the two accesses; store wb_write_en=0.
- Reset mid-ACCESS:
  - Stimulus: assert rst_n low while dmem_req=1, then send an ack after release.
  - Required: FSM in IDLE, no wb_valid pulse.
- Saturation:
  - Stimulus: force a long stall (>65535 cycles).
  - Required: stall_count holds at 0xFFFF.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage pipeline.
//
// Sits between the EX/MEM pipeline register and the write stage.
// - ALU-only instructions go to the WB registers with one cycle of latency.
// - Loads and stores are issued to data memory over a registered req/ack handshake.
//   Upstream is stalled until the ack arrives.
// - A saturating counter tracks the number of stalled cycles.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ex_*                EX/MEM register contents (valid, pc, alu result, store data,
//                       destination reg, write enable, load/store flags)
//   mem_stall           combinational hold request to EX/MEM and earlier stages
//   dmem_req/we/addr/wdata
//                       registered data-memory request
//   dmem_ack/rdata      memory completion; rdata valid with ack
//   wb_*                registered outputs to the write stage
//   stall_count         saturating count of cycles with mem_stall=1
module mem_stage #(
  parameter int unsigned PC_W    = 13,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 3,
  parameter int unsigned DADDR_W = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  // EX/MEM register
  input  logic               ex_valid,
  input  logic [PC_W-1:0]    ex_pc,
  input  logic [DATA_W-1:0]  ex_alu_res,
  input  logic [DATA_W-1:0]  ex_store_data,
  input  logic [REG_W-1:0]   ex_write_reg,
  input  logic               ex_write_en,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  // Pipeline control
  output logic               mem_stall,
  // Data memory
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  // Write stage
  output logic               wb_valid,
  output logic [PC_W-1:0]    wb_pc,
  output logic [DATA_W-1:0]  wb_alu_res,
  output logic [DATA_W-1:0]  wb_mem_data,
  output logic [REG_W-1:0]   wb_write_reg,
  output logic               wb_write_en,
  output logic               wb_mem_read,
  // Statistics
  output logic [15:0]        stall_count
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e state_q, state_d;

  // Memory request registers
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [DADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  // Fields of the instruction parked while the access is outstanding
  logic [PC_W-1:0]    op_pc_q, op_pc_d;
  logic [DATA_W-1:0]  op_alu_q, op_alu_d;
  logic [REG_W-1:0]   op_reg_q, op_reg_d;
  logic               op_wen_q, op_wen_d;
  logic               op_rd_q, op_rd_d;

  // Write-stage registers
  logic               wb_valid_q, wb_valid_d;
  logic [PC_W-1:0]    wb_pc_q, wb_pc_d;
  logic [DATA_W-1:0]  wb_alu_q, wb_alu_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic [REG_W-1:0]   wb_reg_q, wb_reg_d;
  logic               wb_wen_q, wb_wen_d;
  logic               wb_rd_q, wb_rd_d;

  logic [15:0]        stall_cnt_q, stall_cnt_d;

  logic               memop;

  assign memop = ex_valid & (ex_mem_read | ex_mem_write);

  // No path from dmem_rdata: only state, ex control and ack feed the stall.
  always_comb begin
    mem_stall = 1'b0;
    unique case (state_q)
      StIdle:   mem_stall = memop;
      StAccess: mem_stall = ~dmem_ack;
      default:  mem_stall = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_pc_d    = op_pc_q;
    op_alu_d   = op_alu_q;
    op_reg_d   = op_reg_q;
    op_wen_d   = op_wen_q;
    op_rd_d    = op_rd_q;
    wb_valid_d = wb_valid_q;
    wb_pc_d    = wb_pc_q;
    wb_alu_d   = wb_alu_q;
    wb_data_d  = wb_data_q;
    wb_reg_d   = wb_reg_q;
    wb_wen_d   = wb_wen_q;
    wb_rd_d    = wb_rd_q;

    unique case (state_q)
      StIdle: begin
        if (memop) begin
          state_d    = StAccess;
          req_d      = 1'b1;
          // Read+write together issues one access as a store.
          we_d       = ex_mem_write;
          addr_d     = ex_alu_res[DADDR_W-1:0];
          wdata_d    = ex_store_data;
          op_pc_d    = ex_pc;
          op_alu_d   = ex_alu_res;
          op_reg_d   = ex_write_reg;
          op_wen_d   = ex_write_en;
          op_rd_d    = ex_mem_read;
          // Bubble while the access is in flight
          wb_valid_d = 1'b0;
          wb_wen_d   = 1'b0;
        end else if (ex_valid) begin
          wb_valid_d = 1'b1;
          wb_pc_d    = ex_pc;
          wb_alu_d   = ex_alu_res;
          wb_data_d  = '0;
          wb_reg_d   = ex_write_reg;
          wb_wen_d   = ex_write_en;
          wb_rd_d    = ex_mem_read;
        end else begin
          wb_valid_d = 1'b0;
          wb_wen_d   = 1'b0;
        end
      end
      StAccess: begin
        if (dmem_ack) begin
          state_d    = StIdle;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_pc_d    = op_pc_q;
          wb_alu_d   = op_alu_q;
          wb_data_d  = op_rd_q ? dmem_rdata : '0;
          wb_reg_d   = op_reg_q;
          wb_wen_d   = op_wen_q;
          wb_rd_d    = op_rd_q;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (mem_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_pc_q     <= '0;
      op_alu_q    <= '0;
      op_reg_q    <= '0;
      op_wen_q    <= 1'b0;
      op_rd_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_pc_q     <= '0;
      wb_alu_q    <= '0;
      wb_data_q   <= '0;
      wb_reg_q    <= '0;
      wb_wen_q    <= 1'b0;
      wb_rd_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      op_pc_q     <= op_pc_d;
      op_alu_q    <= op_alu_d;
      op_reg_q    <= op_reg_d;
      op_wen_q    <= op_wen_d;
      op_rd_q     <= op_rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_pc_q     <= wb_pc_d;
      wb_alu_q    <= wb_alu_d;
      wb_data_q   <= wb_data_d;
      wb_reg_q    <= wb_reg_d;
      wb_wen_q    <= wb_wen_d;
      wb_rd_q     <= wb_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_pc        = wb_pc_q;
  assign wb_alu_res   = wb_alu_q;
  assign wb_mem_data  = wb_data_q;
  assign wb_write_reg = wb_reg_q;
  assign wb_write_en  = wb_wen_q;
  assign wb_mem_read  = wb_rd_q;
  assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage. Inputs change 1 time unit after each rising edge;
// outputs are sampled at the same point.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [12:0] ex_pc = '0;
  logic [31:0] ex_alu_res = '0;
  logic [31:0] ex_store_data = '0;
  logic [2:0]  ex_write_reg = '0;
  logic        ex_write_en = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [12:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic [12:0] wb_pc;
  logic [31:0] wb_alu_res;
  logic [31:0] wb_mem_data;
  logic [2:0]  wb_write_reg;
  logic        wb_write_en;
  logic        wb_mem_read;
  logic [15:0] stall_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_alu_res   (ex_alu_res),
    .ex_store_data(ex_store_data),
    .ex_write_reg (ex_write_reg),
    .ex_write_en  (ex_write_en),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .mem_stall    (mem_stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .wb_valid     (wb_valid),
    .wb_pc        (wb_pc),
    .wb_alu_res   (wb_alu_res),
    .wb_mem_data  (wb_mem_data),
    .wb_write_reg (wb_write_reg),
    .wb_write_en  (wb_write_en),
    .wb_mem_read  (wb_mem_read),
    .stall_count  (stall_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [12:0] pc, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [2:0] rg, input logic wen,
                        input logic rd, input logic wr);
    ex_valid = v; ex_pc = pc; ex_alu_res = alu; ex_store_data = sd;
    ex_write_reg = rg; ex_write_en = wen; ex_mem_read = rd; ex_mem_write = wr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ex($urandom_range(1, 0) == 1, 13'($urandom), $urandom, $urandom, 3'($urandom),
             $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1);
      dmem_ack = $urandom_range(1, 0) == 1;
      dmem_rdata = $urandom;
      tick();
    end
    set_ex(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    dmem_ack = 1'b0;
    rst_n = 1'b1;
    #1;
    nvec++;
    if ({mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata} !== '0) begin
      nerr++;
      $display("FAIL reset_dmem: got stall=%b req=%b we=%b addr=%h wdata=%h, want all 0",
               mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    nvec++;
    if ({wb_valid, wb_pc, wb_alu_res, wb_mem_data, wb_write_reg, wb_write_en, wb_mem_read,
         stall_count} !== '0) begin
      nerr++;
      $display("FAIL reset_wb: got v=%b pc=%h alu=%h md=%h reg=%h we=%b rd=%b cnt=%h, want 0",
               wb_valid, wb_pc, wb_alu_res, wb_mem_data, wb_write_reg, wb_write_en,
               wb_mem_read, stall_count);
    end
    tick();
  endtask

  task automatic test_alu_passthrough();
    set_ex(1'b1, 13'h0010, 32'h12345678, 32'h0, 3'd5, 1'b1, 1'b0, 1'b0);
    #1;
    nvec++;
    if (mem_stall !== 1'b0) begin
      nerr++; $display("FAIL alu_stall: got %b want 0", mem_stall);
    end
    tick();
    nvec++;
    if ({wb_valid, wb_pc, wb_alu_res, wb_mem_data, wb_write_reg, wb_write_en, wb_mem_read,
         mem_stall} !== {1'b1, 13'h0010, 32'h12345678, 32'h0, 3'd5, 1'b1, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL alu_wb: got v=%b pc=%h alu=%h md=%h reg=%0d we=%b rd=%b stall=%b, want 1 0010 12345678 0 5 1 0 0",
               wb_valid, wb_pc, wb_alu_res, wb_mem_data, wb_write_reg, wb_write_en,
               wb_mem_read, mem_stall);
    end
    set_ex(1'b0, 13'h0FFF, 32'hFFFF_FFFF, 32'h0, 3'd7, 1'b1, 1'b0, 1'b0);
    tick();
    nvec++;
    if ({wb_valid, wb_write_en, wb_pc, wb_alu_res, wb_write_reg} !==
        {1'b0, 1'b0, 13'h0010, 32'h12345678, 3'd5}) begin
      nerr++;
      $display("FAIL alu_idle_hold: got v=%b we=%b pc=%h alu=%h reg=%0d, want 0 0 0010 12345678 5",
               wb_valid, wb_write_en, wb_pc, wb_alu_res, wb_write_reg);
    end
    nvec++;
    if (stall_count !== 16'd0) begin
      nerr++; $display("FAIL alu_count: got %0d want 0", stall_count);
    end
  endtask

  task automatic test_load_wait();
    set_ex(1'b1, 13'h0020, 32'h00001ABC, 32'h1111, 3'd3, 1'b1, 1'b1, 1'b0);
    #1;
    nvec++;
    if (mem_stall !== 1'b1) begin
      nerr++; $display("FAIL load_stall_idle: got %b want 1", mem_stall);
    end
    tick();
    nvec++;
    if ({dmem_req, dmem_we, dmem_addr, wb_valid, mem_stall} !==
        {1'b1, 1'b0, 13'h1ABC, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL load_issue: got req=%b we=%b addr=%h wbv=%b stall=%b, want 1 0 1abc 0 1",
               dmem_req, dmem_we, dmem_addr, wb_valid, mem_stall);
    end
    tick();
    nvec++;
    if ({dmem_req, dmem_addr, wb_valid} !== {1'b1, 13'h1ABC, 1'b0}) begin
      nerr++;
      $display("FAIL load_hold: got req=%b addr=%h wbv=%b, want 1 1abc 0",
               dmem_req, dmem_addr, wb_valid);
    end
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    nvec++;
    if (mem_stall !== 1'b0) begin
      nerr++; $display("FAIL load_stall_ack: got %b want 0", mem_stall);
    end
    tick();
    set_ex(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    dmem_ack = 1'b0;
    nvec++;
    if ({wb_valid, wb_pc, wb_alu_res, wb_mem_data, wb_write_reg, wb_write_en, wb_mem_read,
         dmem_req} !== {1'b1, 13'h0020, 32'h00001ABC, 32'hDEADBEEF, 3'd3, 1'b1, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL load_wb: got v=%b pc=%h alu=%h md=%h reg=%0d we=%b rd=%b req=%b, want 1 0020 00001abc deadbeef 3 1 1 0",
               wb_valid, wb_pc, wb_alu_res, wb_mem_data, wb_write_reg, wb_write_en,
               wb_mem_read, dmem_req);
    end
    nvec++;
    if (stall_count !== 16'd3) begin
      nerr++; $display("FAIL load_count: got %0d want 3", stall_count);
    end
    // A stray ack in IDLE must not produce a WB pulse
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    nvec++;
    if ({wb_valid, dmem_req, mem_stall} !== 3'b000) begin
      nerr++;
      $display("FAIL idle_ack_ignored: got wbv=%b req=%b stall=%b, want 000",
               wb_valid, dmem_req, mem_stall);
    end
  endtask

  task automatic test_back_to_back();
    set_ex(1'b1, 13'h0030, 32'h00000055, 32'hCAFEF00D, 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    nvec++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !==
        {1'b1, 1'b1, 13'h0055, 32'hCAFEF00D}) begin
      nerr++;
      $display("FAIL store_issue: got req=%b we=%b addr=%h wdata=%h, want 1 1 0055 cafef00d",
               dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h5A5A5A5A;
    tick();
    // Upstream advanced on the ack edge: present the load immediately
    set_ex(1'b1, 13'h0034, 32'h00000077, 32'h0, 3'd2, 1'b1, 1'b1, 1'b0);
    dmem_ack = 1'b0;
    nvec++;
    if ({wb_valid, wb_pc, wb_write_en, wb_mem_data, wb_mem_read, dmem_req} !==
        {1'b1, 13'h0030, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL store_wb: got v=%b pc=%h we=%b md=%h rd=%b req=%b, want 1 0030 0 0 0 0",
               wb_valid, wb_pc, wb_write_en, wb_mem_data, wb_mem_read, dmem_req);
    end
    tick();
    nvec++;
    if ({dmem_req, dmem_we, dmem_addr, wb_valid} !== {1'b1, 1'b0, 13'h0077, 1'b0}) begin
      nerr++;
      $display("FAIL load2_issue: got req=%b we=%b addr=%h wbv=%b, want 1 0 0077 0",
               dmem_req, dmem_we, dmem_addr, wb_valid);
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0BADF00D;
    tick();
    dmem_ack = 1'b0;
    // Read+write together: one access, issued as a store, returning load data
    set_ex(1'b1, 13'h0038, 32'h00000099, 32'h13572468, 3'd6, 1'b1, 1'b1, 1'b1);
    nvec++;
    if ({wb_valid, wb_pc, wb_mem_data, wb_write_reg, wb_write_en, stall_count} !==
        {1'b1, 13'h0034, 32'h0BADF00D, 3'd2, 1'b1, 16'd5}) begin
      nerr++;
      $display("FAIL load2_wb: got v=%b pc=%h md=%h reg=%0d we=%b cnt=%0d, want 1 0034 0badf00d 2 1 5",
               wb_valid, wb_pc, wb_mem_data, wb_write_reg, wb_write_en, stall_count);
    end
    tick();
    nvec++;
    if ({dmem_req, dmem_we, dmem_wdata} !== {1'b1, 1'b1, 32'h13572468}) begin
      nerr++;
      $display("FAIL rmw_issue: got req=%b we=%b wdata=%h, want 1 1 13572468",
               dmem_req, dmem_we, dmem_wdata);
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h2468ACE0;
    tick();
    dmem_ack = 1'b0;
    set_ex(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if ({wb_valid, wb_mem_data, wb_mem_read, stall_count} !==
        {1'b1, 32'h2468ACE0, 1'b1, 16'd6}) begin
      nerr++;
      $display("FAIL rmw_wb: got v=%b md=%h rd=%b cnt=%0d, want 1 2468ace0 1 6",
               wb_valid, wb_mem_data, wb_mem_read, stall_count);
    end
  endtask

  task automatic test_reset_mid_access();
    set_ex(1'b1, 13'h0040, 32'h00000123, 32'h0, 3'd1, 1'b1, 1'b1, 1'b0);
    tick();
    set_ex(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({dmem_req, wb_valid, stall_count} !== {1'b0, 1'b0, 16'd0}) begin
      nerr++;
      $display("FAIL midrst_assert: got req=%b wbv=%b cnt=%0d, want 0 0 0",
               dmem_req, wb_valid, stall_count);
    end
    tick();
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF0000;
    tick();
    nvec++;
    if ({wb_valid, dmem_req, wb_mem_data} !== {1'b0, 1'b0, 32'h0}) begin
      nerr++;
      $display("FAIL midrst_late_ack: got wbv=%b req=%b md=%h, want 0 0 0",
               wb_valid, dmem_req, wb_mem_data);
    end
    dmem_ack = 1'b0;
    #1;
    // In ACCESS without ack the stall would be 1; IDLE with no instruction gives 0
    nvec++;
    if (mem_stall !== 1'b0) begin
      nerr++; $display("FAIL midrst_idle: got stall=%b want 0", mem_stall);
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [15:0] mid;
    set_ex(1'b1, 13'h0050, 32'h00000010, 32'h0, 3'd4, 1'b1, 1'b1, 1'b0);
    repeat (1000) tick();
    mid = stall_count;
    nvec++;
    if (mid !== 16'd1000) begin
      nerr++; $display("FAIL sat_progress: got %0d want 1000", mid);
    end
    repeat (64535) tick();
    nvec++;
    if (stall_count !== 16'hFFFF) begin
      nerr++; $display("FAIL sat_reach: got %h want ffff", stall_count);
    end
    repeat (10) tick();
    nvec++;
    if ({stall_count, mem_stall, dmem_req} !== {16'hFFFF, 1'b1, 1'b1}) begin
      nerr++;
      $display("FAIL sat_hold: got cnt=%h stall=%b req=%b, want ffff 1 1",
               stall_count, mem_stall, dmem_req);
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    set_ex(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if ({wb_valid, wb_pc, stall_count} !== {1'b1, 13'h0050, 16'hFFFF}) begin
      nerr++;
      $display("FAIL sat_finish: got wbv=%b pc=%h cnt=%h, want 1 0050 ffff",
               wb_valid, wb_pc, stall_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu_passthrough();
    test_load_wait();
    test_back_to_back();
    test_reset_mid_access();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
